// File: rtl/dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : dcache_wt
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with a
//            req/ack backing-memory port; stalls the pipeline on misses/stores.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_wt #(
    parameter int LINES = 16,
    parameter int WPL   = 4,
    parameter int TAG_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [3:0]  i_cpu_be,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack
);
    localparam int c_IDX_W = $clog2(LINES);
    localparam int c_OFF_W = $clog2(WPL);
    localparam int c_LSB   = 2 + c_OFF_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RDONE  = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [c_OFF_W-1:0]         r_cnt;
    logic                       r_gap;
    logic [31:0]                r_addr;
    logic [3:0]                 r_be;
    logic [31:0]                r_wdata;
    logic [LINES-1:0]           r_valid;
    logic [TAG_W-1:0]           r_tag  [LINES];
    logic [31:0]                r_data [LINES*WPL];

    logic [c_IDX_W-1:0]         w_idx;
    logic [c_OFF_W-1:0]         w_off;
    logic [TAG_W-1:0]           w_tag;
    logic [c_IDX_W-1:0]         w_ridx;
    logic [c_OFF_W-1:0]         w_roff;
    logic [TAG_W-1:0]           w_rtag;
    logic                       w_hit;
    logic                       w_rhit;
    logic                       w_latch;
    logic                       w_clr_valid;
    logic                       w_fill;
    logic                       w_fill_last;
    logic                       w_merge;

    assign w_idx  = i_cpu_addr[c_LSB +: c_IDX_W];
    assign w_off  = i_cpu_addr[2 +: c_OFF_W];
    assign w_tag  = i_cpu_addr[31 -: TAG_W];
    assign w_ridx = r_addr[c_LSB +: c_IDX_W];
    assign w_roff = r_addr[2 +: c_OFF_W];
    assign w_rtag = r_addr[31 -: TAG_W];

    assign w_hit  = i_cpu_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
    assign w_fill_last = w_fill && (&r_cnt);

    always_comb begin
        w_state_nxt = r_state;
        o_cpu_stall = 1'b0;
        o_cpu_rdata = 32'd0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'd0;
        o_mem_addr  = 32'd0;
        o_mem_wdata = 32'd0;
        w_latch     = 1'b0;
        w_clr_valid = 1'b0;
        w_fill      = 1'b0;
        w_merge     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cpu_req) begin
                    if (i_cpu_we) begin
                        o_cpu_stall = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = S_WRITE;
                    end else if (w_hit) begin
                        o_cpu_rdata = r_data[{w_idx, w_off}];
                    end else begin
                        o_cpu_stall = 1'b1;
                        w_latch     = 1'b1;
                        w_clr_valid = 1'b1;
                        w_state_nxt = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                // Request drops for one cycle after each beat so every word
                // is a separate handshake; acks during the gap are ignored.
                o_cpu_stall = 1'b1;
                o_mem_req   = !r_gap;
                o_mem_addr  = {r_addr[31:c_LSB], r_cnt, 2'b00};
                if (!r_gap && i_mem_ack) begin
                    w_fill = 1'b1;
                    if (&r_cnt) begin
                        w_state_nxt = S_RDONE;
                    end
                end
            end
            S_RDONE: begin
                o_cpu_rdata = r_data[{w_ridx, w_roff}];
                w_state_nxt = S_IDLE;
            end
            S_WRITE: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_be    = r_be;
                o_mem_wdata = r_wdata;
                o_mem_addr  = {r_addr[31:2], r_addr[1:0] & 2'b00};
                o_cpu_stall = !i_mem_ack;
                if (i_mem_ack) begin
                    w_merge     = w_rhit;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_valid <= '0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_fill && !(&r_cnt);
            if (w_latch) begin
                r_addr  <= i_cpu_addr;
                r_be    <= i_cpu_be;
                r_wdata <= i_cpu_wdata;
                r_cnt   <= '0;
            end else if (w_fill) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_clr_valid) begin
                r_valid[w_idx] <= 1'b0;
            end
            if (w_fill_last) begin
                r_valid[w_ridx] <= 1'b1;
            end
        end
    end

    // Line storage carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[{w_ridx, r_cnt}] <= i_mem_rdata;
        end
        if (w_fill_last) begin
            r_tag[w_ridx] <= w_rtag;
        end
        if (w_merge) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_data[{w_ridx, w_roff}][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_wt.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_wt
// Brief    : Directed plus randomized bench for dcache_wt with a reference
//            memory / presence model and a req/ack memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    dcache_wt dut (
        .clk         (clk),
        .rst         (rst),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_be    (cpu_be),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_wdata (cpu_wdata),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_stall (cpu_stall),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_be    (mem_be),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] bmem [int unsigned];
    logic [31:0] rmem [int unsigned];
    bit          mvalid [16];
    logic [23:0] mtag   [16];
    txn_t        log_q [$];
    int          ack_dly  = 2;
    bit          ack_rand = 1'b0;
    bit          spur     = 1'b0;
    bit          tog      = 1'b0;
    int          wcnt     = 0;
    logic [31:0] h_addr, h_wd;

    function automatic logic [31:0] init_w(input int unsigned key);
        return (key * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Backing memory: acks a request after ack_dly+1 cycles of mem_req.
    always @(posedge clk) begin
        int unsigned key;
        logic [31:0] cur;
        #1;
        if (rst) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            chk("req_drop_after_ack", 32'(mem_req), 32'd0);
        end else if (mem_req) begin
            wcnt++;
            if (wcnt == 1) begin
                h_addr = mem_addr;
                h_wd   = mem_wdata;
            end else begin
                chk("hold_addr", mem_addr, h_addr);
                if (mem_we) chk("hold_wdata", mem_wdata, h_wd);
            end
            if (wcnt > ack_dly) begin
                mem_ack = 1'b1;
                log_q.push_back('{mem_we, mem_addr, mem_be, mem_wdata});
                key = mem_addr >> 2;
                cur = bmem.exists(key) ? bmem[key] : init_w(key);
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                    bmem[key] = cur;
                end else begin
                    mem_rdata = cur;
                end
                if (ack_rand) ack_dly = $urandom_range(1, 3);
            end
        end else begin
            wcnt = 0;
            if (spur) begin
                tog = !tog;
                if (tog) begin
                    mem_ack   = 1'b1;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned key = a >> 2;
        return rmem.exists(key) ? rmem[key] : init_w(key);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_idle();
        @(negedge clk);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        #1;
        chk("idle_stall", 32'(cpu_stall), 32'd0);
        chk("idle_rdata", cpu_rdata, 32'd0);
        chk("idle_memreq", 32'(mem_req), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a);
        int          idx;
        logic [23:0] t;
        logic [31:0] exp;
        bit          hit;
        int          cyc;
        idx = int'(a[7:4]);
        t   = a[31:8];
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_be = 4'd0; cpu_wdata = 32'd0;
        log_q.delete();
        #1;
        hit = mvalid[idx] && (mtag[idx] == t);
        exp = ref_rd(a);
        if (hit) begin
            chk("hit_stall", 32'(cpu_stall), 32'd0);
            chk("hit_rdata", cpu_rdata, exp);
        end else begin
            chk("miss_stall", 32'(cpu_stall), 32'd1);
            cyc = 0;
            while (cpu_stall === 1'b1 && cyc < 200) begin
                @(negedge clk); #1; cyc++;
            end
            chk("refill_timeout", 32'(cyc < 200), 32'd1);
            chk("rdone_rdata", cpu_rdata, exp);
            chk("refill_count", 32'(log_q.size()), 32'd4);
            for (int i = 0; i < log_q.size() && i < 4; i++) begin
                chk("refill_addr", log_q[i].addr, {a[31:4], 4'd0} + 32'(4 * i));
                chk("refill_we", 32'(log_q[i].we), 32'd0);
            end
            if (!ack_rand) chk("miss_latency", 32'(cyc), 32'd16);
            mvalid[idx] = 1'b1;
            mtag[idx]   = t;
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int          cyc;
        logic [31:0] cur;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
        log_q.delete();
        #1;
        chk("store_stall", 32'(cpu_stall), 32'd1);
        cyc = 0;
        while (cpu_stall === 1'b1 && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        chk("store_timeout", 32'(cyc < 200), 32'd1);
        chk("store_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) begin
            chk("store_we", 32'(log_q[0].we), 32'd1);
            chk("store_addr", log_q[0].addr, {a[31:2], 2'b00});
            chk("store_be", 32'(log_q[0].be), 32'(be));
            chk("store_wdata", log_q[0].wd, wd);
        end
        cur = ref_rd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
        rmem[a >> 2] = cur;
    endtask

    initial begin
        int cyc;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'd0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        rst = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_memreq", 32'(mem_req), 32'd0);
        chk("reset_memwe", 32'(mem_we), 32'd0);

        // Miss/refill then hit; partial store; store miss without allocate
        do_load(32'h100);
        do_load(32'h104);
        do_store(32'h104, 32'hDEADBEEF, 4'b0011);
        do_load(32'h104);
        chk("store_merge_value", ref_rd(32'h104), {init_w(32'h41) >> 16, 16'hBEEF});
        do_store(32'h800, 32'h12345678, 4'b1111);
        do_load(32'h800);
        do_load(32'h100);
        do_load(32'h200);
        do_load(32'h100);

        // Reset during the third refill beat
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        log_q.delete();
        #1;
        chk("rst_test_miss", 32'(cpu_stall), 32'd1);
        cyc = 0;
        while (!(log_q.size() == 2 && mem_req === 1'b1 && mem_ack === 1'b0) && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        chk("rst_test_reach", 32'(cyc < 200), 32'd1);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrefill_rst_stall", 32'(cpu_stall), 32'd0);
        chk("midrefill_rst_memreq", 32'(mem_req), 32'd0);
        clear_model();
        do_load(32'h100);

        // Spurious acks while idle
        spur = 1'b1;
        repeat (8) do_idle();
        spur = 1'b0;
        repeat (2) do_idle();
        do_load(32'h100);
        do_load(32'h10C);

        // Randomized traffic over a few tags so lines alias and wrap
        ack_rand = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            if (r < 6)      do_load(a);
            else if (r < 8) do_store(a, $urandom, 4'($urandom_range(1, 15)));
            else            do_idle();
        end
        do_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
